div_iter_unit: RTL and testbench
================================

Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage. Executes DIV and DIVU.
- Drives stallreq_o into the pipeline controller's EX stall request. This holds IF/ID/EX until the quotient and remainder are ready.
- result_o is forwarded to the MEM-stage hi/lo write path: hi = remainder, lo = quotient.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH wide.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start_i  in  1  EX holds a divide instruction; stays high until ready_o is seen.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- annul_i  in  1  kill the in-flight operation (flush/exception).
- opdata1_i  in  WIDTH  dividend (rs).
- opdata2_i  in  WIDTH  divisor (rt).
- result_o  out  2*WIDTH  {remainder, quotient}, registered.
- ready_o  out  1  result_o valid this cycle, registered.
- stallreq_o  out  1  to the controller's stallreq_for_ex.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, result_o=0, ready_o=0.
- States: IDLE, DIV_ZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 and opdata2_i==0 → DIV_ZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 → ON. Latch |opdata1_i|, |opdata2_i|, the sign flags and signed_i; clear cnt and the partial remainder.
  - Magnitudes are taken only when signed_i=1.
- ON: one iteration per cycle.
  - Shift {rem,quot} left 1 bit.
  - If the shifted rem ≥ divisor: subtract, set quot LSB=1.
  - Use a WIDTH+1-bit compare with no overflow.
  - Go to END after iteration 31 (cnt==WIDTH-1).
- DIV_ZERO: result register loads 0 → END.
- END:
  - ready_o=1; result_o holds the final value. For DIV, negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Unconditionally go to IDLE next cycle.
- ready_o is high only in END; result_o holds until the next END or reset.
- stallreq_o = start_i & ~ready_o & ~annul_i (combinational).
- Latency: start sampled in IDLE at cycle 0 → ready_o at cycle WIDTH+1 (33); divide-by-zero → ready_o at cycle 2.
- Operand changes while ON are ignored.
- start_i held high in IDLE after END begins a new divide; EX must drop start_i once ready_o is seen.
- annul_i=1 in any state → IDLE next cycle; ready_o=0; result_o unchanged.
- 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0 (wraps, no trap).

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |dividend| < |divisor| (unsigned compare, divisor != 0), go directly to END with quotient 0 and remainder = the original signed dividend. ready_o comes at cycle 2.
- Undefined: such operands take the full WIDTH+1 cycles.
- Results are identical either way.

Decomposition:
- Package div_defs:
  - state encodings DIV_IDLE/DIV_ZERO/DIV_ON/DIV_END (2 bits);
  - default WIDTH;
  - result field offsets REM_HI/QUOT_LO.
- Sub-module div_sign_fix (combinational): conditional two's-complement negate, used for operand magnitude and result sign correction.
- Everything else stays in div_iter_unit.

Test Plan:
- DIVU 100/7 → stallreq_o high cycles 0–32; cycle 33: ready_o=1, result_o={0x00000002,0x0000000E}; cycle 34 IDLE.
- DIV -7/2 (0xFFFFFFF9/0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF at cycle 33.
- DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0; DIVU 5/0 → result_o=0, ready_o at cycle 2.
- Pulse annul_i at cycle 10 → IDLE at cycle 11, ready_o never asserted, result_o keeps its previous value; the next start completes normally.
- rst driven low mid-ON (cycle 15, asynchronous, between edges) → outputs zero immediately; after release, a DIVU 9/3 returns {0,3} at cycle 33.
- With DIV_EARLY_OUT_EN: DIVU 3/10 → ready_o at cycle 2, result_o={0x00000003,0}. Without it → same result at cycle 33.

Source files
------------

// File: rtl/div_iter_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_defs
//   Shared definitions for the iterative divider slice.
//   - DIV_WIDTH       : default operand width of div_iter_unit.
//   - DIV_IDLE/ZERO/ON/END : 2-bit FSM state encodings.
//   - QUOT_LO / REM_HI: bit positions of the quotient LSB and the remainder
//                       MSB inside the packed {remainder, quotient} result
//                       (REM_HI assumes the default width).
// -----------------------------------------------------------------------------
package div_defs;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON   = 2'b10;
  localparam logic [1:0] DIV_END  = 2'b11;

  localparam int QUOT_LO = 0;
  localparam int REM_HI  = 2 * DIV_WIDTH - 1;

endpackage

// File: rtl/div_iter_unit_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
//   Conditional two's-complement negate. Used both to take operand magnitudes
//   and to restore the sign of the quotient and remainder.
//   Ports:
//     neg  : 1 = output the negation of din, 0 = pass din through
//     din  : WIDTH-bit input value
//     dout : WIDTH-bit result (wraps, so the most negative value maps to itself)
// -----------------------------------------------------------------------------
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (WIDTH'(0) - din) : din;

endmodule

// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
//   Multi-cycle radix-2 restoring divider for the EX stage (DIV / DIVU).
//   One quotient bit per cycle; holds the pipeline through stallreq_o until
//   the {remainder, quotient} result is ready.
//
//   Ports:
//     clk        : core clock, rising edge
//     rst        : asynchronous reset, active low
//     start_i    : divide requested; held until ready_o is seen
//     signed_i   : 1 = DIV (two's complement), 0 = DIVU
//     annul_i    : kill the in-flight operation (flush / exception)
//     opdata1_i  : dividend
//     opdata2_i  : divisor
//     result_o   : {remainder, quotient}, registered, held until next result
//     ready_o    : result_o valid this cycle (one cycle, registered)
//     stallreq_o : EX stall request to the pipeline controller
//
//   Build option:
//     DIV_EARLY_OUT_EN : when |dividend| < |divisor| skip the iterations;
//                        the result is identical, only latency changes.
// -----------------------------------------------------------------------------
module div_iter_unit
  import div_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam int               REM_LO   = QUOT_LO + WIDTH;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] quot_q;     // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] dvsr_q;     // divisor magnitude, frozen for the operation
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] rem_sel;
  logic [WIDTH-1:0] quot_sel;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quot_fix;

  // Operand magnitudes; DIVU operands pass through untouched.
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .neg  (signed_i & opdata1_i[WIDTH-1]),
    .din  (opdata1_i),
    .dout (abs_a)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .neg  (signed_i & opdata2_i[WIDTH-1]),
    .din  (opdata2_i),
    .dout (abs_b)
  );

  // One restoring step. The shifted remainder is WIDTH+1 bits so the compare
  // against the divisor cannot overflow; the difference always fits in WIDTH.
  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    rem_sh    = {rem_q, quot_q[WIDTH-1]};
    take      = (rem_sh >= {1'b0, dvsr_q});
    rem_next  = take ? WIDTH'(rem_sh - {1'b0, dvsr_q}) : rem_sh[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], take};
  end

  // The last iteration writes the result straight from the step logic; the
  // short paths (divide by zero, early out) load it from the registers.
  assign rem_sel  = (state_q == DIV_ON) ? rem_next  : rem_q;
  assign quot_sel = (state_q == DIV_ON) ? quot_next : quot_q;

  // Quotient is negative when operand signs differ; remainder follows dividend.
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .neg  (neg_quot_q),
    .din  (quot_sel),
    .dout (quot_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .neg  (neg_rem_q),
    .din  (rem_sel),
    .dout (rem_fix)
  );

`ifdef DIV_EARLY_OUT_EN
  logic early_out;
  assign early_out = (abs_a < abs_b);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  // NOTE: all of these are plain control/datapath registers (no memory
  // arrays), so each one is given a defined reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i) begin
        // Flush wins over everything; result_o keeps the last good value.
        state_q <= DIV_IDLE;
      end else begin
        case (state_q)
          DIV_IDLE: begin
            if (start_i) begin
              neg_quot_q <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem_q  <= signed_i & opdata1_i[WIDTH-1];
              if (opdata2_i == '0) begin
                // Zeros stay zero after sign correction, so the result is 0.
                rem_q   <= '0;
                quot_q  <= '0;
                state_q <= DIV_ZERO;
`ifdef DIV_EARLY_OUT_EN
              end else if (early_out) begin
                // Quotient 0, remainder is the dividend itself; reuses the
                // one-cycle load state so latency matches divide-by-zero.
                rem_q   <= abs_a;
                quot_q  <= '0;
                state_q <= DIV_ZERO;
`endif
              end else begin
                rem_q   <= '0;
                quot_q  <= abs_a;
                dvsr_q  <= abs_b;
                cnt_q   <= '0;
                state_q <= DIV_ON;
              end
            end
          end

          DIV_ON: begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              result_o[REM_LO +: WIDTH]  <= rem_fix;
              result_o[QUOT_LO +: WIDTH] <= quot_fix;
              ready_o                    <= 1'b1;
              state_q                    <= DIV_END;
            end
          end

          DIV_ZERO: begin
            result_o[REM_LO +: WIDTH]  <= rem_fix;
            result_o[QUOT_LO +: WIDTH] <= quot_fix;
            ready_o                    <= 1'b1;
            state_q                    <= DIV_END;
          end

          DIV_END: begin
            state_q <= DIV_IDLE;
          end

          default: begin
            state_q <= DIV_IDLE;
          end
        endcase
      end
    end
  end

  assign stallreq_o = start_i & ~ready_o & ~annul_i;

endmodule

// File: tb/tb_div_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_div_iter_unit
//   Self-checking bench for div_iter_unit. Expected {remainder, quotient} and
//   latency are pushed to a scoreboard when an operation is issued and popped
//   when ready_o arrives. Cycle 0 is the cycle in which start_i is sampled in
//   IDLE; latency is the cycle number in which ready_o is high.
// -----------------------------------------------------------------------------
module tb_div_iter_unit;
  import div_defs::*;

  localparam int W      = 32;
  localparam int BUDGET = 100;

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
    string          name;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic           annul_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_o;

  int             checks = 0;
  int             errors = 0;
  exp_t           sb[$];
  logic [2*W-1:0] last_res = '0;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .annul_i    (annul_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: divide the magnitudes, then apply the architectural signs.
  function automatic logic [2*W-1:0] model(logic sgn, logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] ma, mb, q, r;
    if (b == '0) return '0;
    ma = (sgn && a[W-1]) ? (W'(0) - a) : a;
    mb = (sgn && b[W-1]) ? (W'(0) - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[W-1] ^ b[W-1])) q = W'(0) - q;
    if (sgn && a[W-1])            r = W'(0) - r;
    return {r, q};
  endfunction

  function automatic int exp_lat(logic sgn, logic [W-1:0] a, logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [W-1:0] ma, mb;
    ma = (sgn && a[W-1]) ? (W'(0) - a) : a;
    mb = (sgn && b[W-1]) ? (W'(0) - b) : b;
    if (b != '0 && ma < mb) return 2;
`endif
    if (b == '0) return 2;
    return W + 1;
  endfunction

  // Issue one divide at the next falling edge and wait for ready_o. Operands
  // are scrambled after cycle 0 since the unit must ignore them. stall_ok
  // records whether stallreq_o was high before ready_o and low with it.
  task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit keep, output logic [2*W-1:0] res, output int lat,
                        output bit stall_ok);
    int cyc;
    stall_ok = 1'b1;
    lat      = -1;
    res      = 'x;
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    #1;
    cyc = 0;
    while (cyc <= BUDGET) begin
      if (ready_o === 1'b1) begin
        lat = cyc;
        res = result_o;
        if (stallreq_o !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stallreq_o !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = 1'($urandom);
      end
    end
    if (!keep) start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", ready_o);
    end
    checks++;
    if (result_o !== '0) begin
      errors++; $display("FAIL reset_result: got %h want 0", result_o);
    end
    checks++;
    if (stallreq_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b want 0", stallreq_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu();
    logic [2*W-1:0] res;
    int lat;
    bit sok;
    exp_t e;
    logic [W-1:0] a, b;
    sb.push_back('{{32'h0000_0002, 32'h0000_000E}, W + 1, "divu_100_7"});
    do_div(1'b0, 32'd100, 32'd7, 1'b0, res, lat, sok);
    e = sb.pop_front();
    checks++;
    if (res !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", e.name, res, e.res); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
    checks++;
    if (!sok) begin errors++; $display("FAIL %s stallreq: got bad profile want high until ready", e.name); end
    last_res = e.res;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL divu_idle_after_end: got %b want 0", ready_o); end
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i < 2) ? W'($urandom_range(1, 1000)) : W'($urandom);
      if (b == '0) b = 1;
      sb.push_back('{model(1'b0, a, b), exp_lat(1'b0, a, b), "divu_rand"});
      do_div(1'b0, a, b, 1'b0, res, lat, sok);
      e = sb.pop_front();
      checks++;
      if (res !== e.res) begin errors++; $display("FAIL %s result %h/%h: got %h want %h", e.name, a, b, res, e.res); end
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      last_res = e.res;
    end
  endtask

  task automatic test_div_signed();
    logic [W-1:0] ta[5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd1234567, 32'hFFFF_0000, 32'h7FFF_FFFF};
    logic [W-1:0] tb[5] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'hFFFF_FFF3, 32'd3};
    logic [2*W-1:0] fixed[2] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000}};
    logic [2*W-1:0] res;
    int lat;
    bit sok;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{(i < 2) ? fixed[i] : model(1'b1, ta[i], tb[i]),
                     exp_lat(1'b1, ta[i], tb[i]), "div_signed"});
      do_div(1'b1, ta[i], tb[i], 1'b0, res, lat, sok);
      e = sb.pop_front();
      checks++;
      if (res !== e.res) begin errors++; $display("FAIL %s %h/%h: got %h want %h", e.name, ta[i], tb[i], res, e.res); end
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      checks++;
      if (!sok) begin errors++; $display("FAIL %s stallreq: got bad profile want high until ready", e.name); end
      last_res = e.res;
    end
  endtask

  task automatic test_div_zero();
    logic           sg[2] = '{1'b0, 1'b1};
    logic [W-1:0]   ta[2] = '{32'd5, 32'hFFFF_FFFB};
    logic [2*W-1:0] res;
    int lat;
    bit sok;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{'0, 2, "div_by_zero"});
      do_div(sg[i], ta[i], '0, 1'b0, res, lat, sok);
      e = sb.pop_front();
      checks++;
      if (res !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", e.name, res, e.res); end
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      checks++;
      if (!sok) begin errors++; $display("FAIL %s stallreq: got bad profile want high until ready", e.name); end
      last_res = e.res;
    end
  endtask

  task automatic test_annul();
    logic [2*W-1:0] res;
    int lat;
    bit sok;
    int seen;
    exp_t e;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0) begin errors++; $display("FAIL annul_stall: got %b want 0", stallreq_o); end
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL annul_ready: got %0d ready cycles want 0", seen); end
    checks++;
    if (result_o !== last_res) begin errors++; $display("FAIL annul_result_held: got %h want %h", result_o, last_res); end
    sb.push_back('{model(1'b0, 32'd1000, 32'd3), W + 1, "after_annul"});
    do_div(1'b0, 32'd1000, 32'd3, 1'b0, res, lat, sok);
    e = sb.pop_front();
    checks++;
    if (res !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", e.name, res, e.res); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
    last_res = e.res;
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0] res;
    int lat;
    bit sok;
    exp_t e;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd77777; opdata2_i = 32'd5;
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (result_o !== '0) begin errors++; $display("FAIL async_rst_result: got %h want 0", result_o); end
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL async_rst_ready: got %b want 0", ready_o); end
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    sb.push_back('{{32'h0, 32'h3}, W + 1, "divu_9_3_after_rst"});
    do_div(1'b0, 32'd9, 32'd3, 1'b0, res, lat, sok);
    e = sb.pop_front();
    checks++;
    if (res !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", e.name, res, e.res); end
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
    last_res = e.res;
  endtask

  task automatic test_early_out();
    logic           sg[2] = '{1'b0, 1'b1};
    logic [W-1:0]   ta[2] = '{32'd3, 32'hFFFF_FFFD};
    logic [2*W-1:0] fixed[2] = '{{32'h3, 32'h0}, {32'hFFFF_FFFD, 32'h0}};
    logic [2*W-1:0] res;
    int lat;
    bit sok;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
`ifdef DIV_EARLY_OUT_EN
      sb.push_back('{fixed[i], 2, "small_dividend"});
`else
      sb.push_back('{fixed[i], W + 1, "small_dividend"});
`endif
      do_div(sg[i], ta[i], 32'd10, 1'b0, res, lat, sok);
      e = sb.pop_front();
      checks++;
      if (res !== e.res) begin errors++; $display("FAIL %s result: got %h want %h", e.name, res, e.res); end
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      last_res = e.res;
    end
  endtask

  // start_i stays high across END: the IDLE cycle after END begins the next op.
  task automatic test_back_to_back();
    logic [2*W-1:0] res;
    int lat;
    bit sok;
    exp_t e;
    sb.push_back('{{32'h2, 32'hE}, W + 1, "b2b_first"});
    sb.push_back('{{32'hFFFF_FFFE, 32'hFFFF_FFF2}, W + 1, "b2b_second"});
    do_div(1'b0, 32'd100, 32'd7, 1'b1, res, lat, sok);
    e = sb.pop_front();
    checks++;
    if (res !== e.res || lat !== e.lat) begin
      errors++; $display("FAIL %s: got %h@%0d want %h@%0d", e.name, res, lat, e.res, e.lat);
    end
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, res, lat, sok);
    e = sb.pop_front();
    checks++;
    if (res !== e.res || lat !== e.lat) begin
      errors++; $display("FAIL %s: got %h@%0d want %h@%0d", e.name, res, lat, e.res, e.lat);
    end
    checks++;
    if (res[REM_HI -: W] !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL b2b_rem_field: got %h want fffffffe", res[REM_HI -: W]);
    end
  endtask

  initial begin
    start_i   = 1'b0;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_annul();
    test_async_reset();
    test_early_out();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
